// File: rtl/mux4_arbiter.sv
// Four-way round-robin arbiter with burst-limited grants
// driving a registered 4:1 single-bit data mux.
module mux4_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] in,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       out,
  output logic       out_vld,
  output logic       busy
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t     state;
  logic [1:0] last;
  logic [3:0] cnt;

  logic       any;
  logic [1:0] win;
  logic [1:0] idx;
  logic [3:0] cnt_nxt;
  logic       burst_done;
  logic       release_gnt;

  // Scan from lowest to highest priority so the
  // highest-priority requester is the final assignment.
  always_comb begin
    any = 1'b0;
    win = last;
    idx = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) begin
        any = 1'b1;
        win = idx;
      end
    end
  end

  assign cnt_nxt     = cnt + 4'd1;
  assign burst_done  = (cnt_nxt == 4'(MAX_BURST));
  assign release_gnt = !req[sel] || burst_done;
  assign busy        = (state == BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= 4'b0000;
      sel     <= 2'd0;
      last    <= 2'd3;
      cnt     <= 4'd0;
      out     <= 1'b0;
      out_vld <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          out_vld <= 1'b0;
          if (any) begin
            state <= BUSY;
            gnt   <= 4'b0001 << win;
            sel   <= win;
            last  <= win;
            cnt   <= 4'd0;
          end
        end
        BUSY: begin
          if (req[sel]) begin
            out     <= in[sel];
            out_vld <= 1'b1;
            cnt     <= cnt_nxt;
          end else begin
            out_vld <= 1'b0;
          end
          // last equals sel here, so the holder
          // naturally ranks lowest on re-arbitration.
          if (release_gnt) begin
            cnt <= 4'd0;
            if (any) begin
              gnt  <= 4'b0001 << win;
              sel  <= win;
              last <= win;
            end else begin
              state <= IDLE;
              gnt   <= 4'b0000;
            end
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_arbiter.sv
// Bench for mux4_arbiter: vector table, hand sequences
// and random traffic against a behavioural model.
module tb_mux4_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] in;

  logic [3:0] g0, g1;
  logic [1:0] s0, s1;
  logic       o0, o1, v0, v1, b0, b1;

  mux4_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req(req), .in(in),
    .gnt(g0), .sel(s0), .out(o0),
    .out_vld(v0), .busy(b0)
  );

  mux4_arbiter #(.MAX_BURST(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .in(in),
    .gnt(g1), .sel(s1), .out(o1),
    .out_vld(v1), .busy(b1)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       r;
    logic [3:0] rq;
    logic [3:0] d;
    logic [3:0] g;
    logic [1:0] s;
    logic       o;
    logic       v;
    logic       b;
  } vec_t;

  vec_t tbl[$];

  // Model: holder index (-1 = none), transfers in burst,
  // last granted, held sel, captured data and valid.
  int m_hold[2];
  int m_cnt[2];
  int m_last[2];
  int m_sel[2];
  bit m_o[2];
  bit m_v[2];

  task automatic add(logic r, logic [3:0] rq,
                     logic [3:0] d, logic [3:0] g,
                     int s, logic o, logic v, logic b);
    vec_t e;
    e.r = r; e.rq = rq; e.d = d; e.g = g;
    e.s = 2'(s); e.o = o; e.v = v; e.b = b;
    tbl.push_back(e);
  endtask

  task automatic chk(string nm, int a, int e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t",
               nm, a, e, $time);
    end
  endtask

  function automatic int pick(logic [3:0] rq, int lst);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (lst + k) % 4;
      if (rq[i]) return i;
    end
    return -1;
  endfunction

  task automatic grant_to(int m, int w);
    m_hold[m] = w;
    m_last[m] = w;
    m_sel[m]  = w;
    m_cnt[m]  = 0;
  endtask

  task automatic model(int m, int mb);
    int w;
    bit rel;
    if (rst) begin
      m_hold[m] = -1; m_cnt[m] = 0; m_last[m] = 3;
      m_sel[m] = 0; m_o[m] = 0; m_v[m] = 0;
      return;
    end
    w = pick(req, m_last[m]);
    if (m_hold[m] < 0) begin
      m_v[m] = 0;
      if (w >= 0) grant_to(m, w);
    end else begin
      rel = 0;
      if (req[m_hold[m]]) begin
        m_o[m] = in[m_hold[m]];
        m_v[m] = 1;
        m_cnt[m]++;
        rel = (m_cnt[m] == mb);
      end else begin
        m_v[m] = 0;
        rel = 1;
      end
      if (rel) begin
        if (w >= 0) grant_to(m, w);
        else m_hold[m] = -1;
      end
    end
  endtask

  task automatic cmp_model(int m);
    int eg;
    eg = (m_hold[m] < 0) ? 0 : (1 << m_hold[m]);
    if (m == 0) begin
      chk("m4_gnt", int'(g0), eg);
      chk("m4_sel", int'(s0), m_sel[0]);
      chk("m4_out", int'(o0), int'(m_o[0]));
      chk("m4_vld", int'(v0), int'(m_v[0]));
      chk("m4_busy", int'(b0), int'(m_hold[0] >= 0));
    end else begin
      chk("m1_gnt", int'(g1), eg);
      chk("m1_sel", int'(s1), m_sel[1]);
      chk("m1_out", int'(o1), int'(m_o[1]));
      chk("m1_vld", int'(v1), int'(m_v[1]));
      chk("m1_busy", int'(b1), int'(m_hold[1] >= 0));
    end
  endtask

  task automatic step(logic r, logic [3:0] rq,
                      logic [3:0] d, bit glitch);
    rst = r; req = rq; in = d;
    model(0, 4);
    model(1, 1);
    if (glitch) begin
      #2 rst = 1'b1;
      #2 rst = 1'b0;
    end
    @(posedge clk);
    #1;
    cmp_model(0);
    cmp_model(1);
  endtask

  initial begin
    int ht, hg;
    logic [3:0] rq;
    rst = 1'b1; req = '0; in = '0;

    // single requester 2, continuous bursts
    add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0);
    add(0, 4'b0100, 4'b0100, 4'b0100, 2, 0, 0, 1);
    for (int e = 2; e <= 9; e++)
      add(0, 4'b0100, 4'b0100, 4'b0100, 2, 1, 1, 1);

    // all requesting, data path with in = 1010
    add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0);
    add(0, 4'b1111, 4'b1010, 4'b0001, 0, 0, 0, 1);
    for (int e = 2; e <= 18; e++) begin
      ht = ((e - 2) / 4) % 4;
      hg = ((e - 1) / 4) % 4;
      add(0, 4'b1111, 4'b1010, 4'(1 << hg), hg,
          ht[0], 1, 1);
    end

    // early release from 1 to 3, then going idle
    add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0);
    add(0, 4'b1010, 4'b1010, 4'b0010, 1, 0, 0, 1);
    add(0, 4'b1010, 4'b1010, 4'b0010, 1, 1, 1, 1);
    add(0, 4'b1010, 4'b1010, 4'b0010, 1, 1, 1, 1);
    add(0, 4'b1000, 4'b0000, 4'b1000, 3, 1, 0, 1);
    add(0, 4'b1000, 4'b1000, 4'b1000, 3, 1, 1, 1);
    add(0, 4'b0000, 4'b0000, 4'b0000, 3, 1, 0, 0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 3, 1, 0, 0);

    // reset in the middle of requester 3's burst
    add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0);
    add(0, 4'b1000, 4'b1000, 4'b1000, 3, 0, 0, 1);
    add(0, 4'b1000, 4'b1000, 4'b1000, 3, 1, 1, 1);
    add(1, 4'b1000, 4'b1000, 4'b0000, 0, 0, 0, 0);
    add(0, 4'b1010, 4'b0000, 4'b0010, 1, 0, 0, 1);
    add(0, 4'b1010, 4'b0000, 4'b0010, 1, 0, 1, 1);

    step(1, 4'b0000, 4'b0000, 0);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].rq, tbl[i].d, 0);
      chk($sformatf("v%0d_gnt", i), int'(g0), int'(tbl[i].g));
      chk($sformatf("v%0d_sel", i), int'(s0), int'(tbl[i].s));
      chk($sformatf("v%0d_out", i), int'(o0), int'(tbl[i].o));
      chk($sformatf("v%0d_vld", i), int'(v0), int'(tbl[i].v));
      chk($sformatf("v%0d_busy", i), int'(b0), int'(tbl[i].b));
    end

    // rst pulsed between edges must be ignored
    step(0, 4'b1010, 4'b0010, 1);
    chk("glitch_busy", int'(b0), 1);
    chk("glitch_gnt", int'(g0), 4'b0010);
    chk("glitch_vld", int'(v0), 1);

    // one transfer per grant rotation
    step(1, 4'b0000, 4'b0000, 0);
    for (int k = 1; k <= 6; k++) begin
      step(0, 4'b1111, 4'b0101, 0);
      chk($sformatf("rot%0d_gnt", k), int'(g1),
          1 << ((k - 1) % 4));
    end

    step(1, 4'b0000, 4'b0000, 0);
    rq = 4'b0000;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0)
        rq = 4'($urandom_range(0, 15));
      step(logic'($urandom_range(0, 63) == 0), rq,
           4'($urandom_range(0, 15)), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
